// File: rtl/masked_pkg.sv
// Shared helpers for the masked Kogge-Stone adder: prefix depth, randomness
// budget and per-level randomness offsets, all as constant functions.
package masked_pkg;

  localparam int MAX_WIDTH = 64;

  typedef struct packed {
    logic [MAX_WIDTH-1:0] sh0;
    logic [MAX_WIDTH-1:0] sh1;
  } share_pair_t;

  function automatic bit ks_width_ok(input int width);
    return (width >= 2) && ((width & (width - 1)) == 0);
  endfunction

  function automatic int ks_levels(input int width);
    int lv;
    lv = 0;
    for (int k = 0; (1 << k) < width; k++) lv = k + 1;
    return lv;
  endfunction

  // Stage 0 takes the lowest width bits; level l then takes 2*(width-2^l).
  function automatic int ks_rnd_off(input int width, input int level);
    int off;
    off = width;
    for (int k = 0; k < level; k++) off += 2 * (width - (1 << k));
    return off;
  endfunction

  function automatic int ks_rnd_w(input int width);
    return ks_rnd_off(width, ks_levels(width));
  endfunction

endpackage

// File: rtl/dom_and_reg.sv
// One-bit registered DOM AND: the four partial products are registered and
// compressed per domain only after the register.
module dom_and_reg
  import masked_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic x0,
  input  logic x1,
  input  logic y0,
  input  logic y1,
  input  logic z,
  output logic q0,
  output logic q1
);

  logic t00_p0, t01_p0, t10_p0, t11_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      t00_p0 <= 1'b0;
      t01_p0 <= 1'b0;
      t10_p0 <= 1'b0;
      t11_p0 <= 1'b0;
    end else if (en) begin
      t00_p0 <= x0 & y0;
      t01_p0 <= (x0 & y1) ^ z;
      t10_p0 <= (x1 & y0) ^ z;
      t11_p0 <= x1 & y1;
    end
  end

  assign q0 = t00_p0 ^ t01_p0;
  assign q1 = t10_p0 ^ t11_p0;

endmodule

// File: rtl/masked_ks_adder.sv
// Pipelined two-share DOM-masked Kogge-Stone adder; every non-linear stage is
// registered, consumes fresh randomness and is enabled by its own valid bit.
module masked_ks_adder
  import masked_pkg::*;
#(
  parameter  int WIDTH  = 8,
  localparam int LEVELS = ks_levels(WIDTH),
  localparam int RND_W  = ks_rnd_w(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a0,
  input  logic [WIDTH-1:0] i_a1,
  input  logic [WIDTH-1:0] i_b0,
  input  logic [WIDTH-1:0] i_b1,
  input  logic [RND_W-1:0] i_rnd,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_s0,
  output logic [WIDTH-1:0] o_s1,
  output logic             o_cout0,
  output logic             o_cout1
);

  if (!ks_width_ok(WIDTH) || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("masked_ks_adder: WIDTH must be a power of two between 2 and %0d", MAX_WIDTH);
  end

  // Index k holds the G/P shares entering level k; index LEVELS feeds the output stage.
  wire  [WIDTH-1:0] g_s0 [0:LEVELS];
  wire  [WIDTH-1:0] g_s1 [0:LEVELS];
  wire  [WIDTH-1:0] p_s0 [0:LEVELS];
  wire  [WIDTH-1:0] p_s1 [0:LEVELS];

  logic [LEVELS:0]  vld_p;
  logic [WIDTH-1:0] pd0_p [0:LEVELS];
  logic [WIDTH-1:0] pd1_p [0:LEVELS];

  // ---- stage 0: generate via DOM AND, propagate is linear per share ----
  for (genvar i = 0; i < WIDTH; i++) begin : g_stage0
    dom_and_reg u_g (
      .clk (i_clk),
      .rst (i_rst),
      .en  (i_valid),
      .x0  (i_a0[i]),
      .x1  (i_a1[i]),
      .y0  (i_b0[i]),
      .y1  (i_b1[i]),
      .z   (i_rnd[i]),
      .q0  (g_s0[0][i]),
      .q1  (g_s1[0][i])
    );
  end

  assign p_s0[0] = pd0_p[0];
  assign p_s1[0] = pd1_p[0];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vld_p <= '0;
      for (int k = 0; k <= LEVELS; k++) begin
        pd0_p[k] <= '0;
        pd1_p[k] <= '0;
      end
    end else begin
      vld_p <= {vld_p[LEVELS-1:0], i_valid};
      if (i_valid) begin
        pd0_p[0] <= i_a0 ^ i_b0;
        pd1_p[0] <= i_a1 ^ i_b1;
      end
      for (int k = 0; k < LEVELS; k++) begin
        if (vld_p[k]) begin
          pd0_p[k+1] <= pd0_p[k];
          pd1_p[k+1] <= pd1_p[k];
        end
      end
    end
  end

  // ---- prefix levels: distance D = 2^l, each level one register deep ----
  for (genvar l = 0; l < LEVELS; l++) begin : g_level
    localparam int D   = 1 << l;
    localparam int OFF = ks_rnd_off(WIDTH, l);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_mix
        logic gk0_p, gk1_p;
        logic gq0, gq1, pq0, pq1;

        dom_and_reg u_gg (
          .clk (i_clk),
          .rst (i_rst),
          .en  (vld_p[l]),
          .x0  (p_s0[l][i]),
          .x1  (p_s1[l][i]),
          .y0  (g_s0[l][i-D]),
          .y1  (g_s1[l][i-D]),
          .z   (i_rnd[OFF+i-D]),
          .q0  (gq0),
          .q1  (gq1)
        );

        dom_and_reg u_pp (
          .clk (i_clk),
          .rst (i_rst),
          .en  (vld_p[l]),
          .x0  (p_s0[l][i]),
          .x1  (p_s1[l][i]),
          .y0  (p_s0[l][i-D]),
          .y1  (p_s1[l][i-D]),
          .z   (i_rnd[OFF+WIDTH-D+i-D]),
          .q0  (pq0),
          .q1  (pq1)
        );

        // The linear G_i term is delayed so it lines up with the registered product.
        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            gk0_p <= 1'b0;
            gk1_p <= 1'b0;
          end else if (vld_p[l]) begin
            gk0_p <= g_s0[l][i];
            gk1_p <= g_s1[l][i];
          end
        end

        assign g_s0[l+1][i] = gk0_p ^ gq0;
        assign g_s1[l+1][i] = gk1_p ^ gq1;
        assign p_s0[l+1][i] = pq0;
        assign p_s1[l+1][i] = pq1;
      end else begin : g_pass
        logic g0_p, g1_p, p0_p, p1_p;

        always_ff @(posedge i_clk or posedge i_rst) begin
          if (i_rst) begin
            g0_p <= 1'b0;
            g1_p <= 1'b0;
            p0_p <= 1'b0;
            p1_p <= 1'b0;
          end else if (vld_p[l]) begin
            g0_p <= g_s0[l][i];
            g1_p <= g_s1[l][i];
            p0_p <= p_s0[l][i];
            p1_p <= p_s1[l][i];
          end
        end

        assign g_s0[l+1][i] = g0_p;
        assign g_s1[l+1][i] = g1_p;
        assign p_s0[l+1][i] = p0_p;
        assign p_s1[l+1][i] = p1_p;
      end
    end
  end

  // The final-level group propagate has no consumer.
  wire unused_p0 = &p_s0[LEVELS];
  wire unused_p1 = &p_s1[LEVELS];

  // ---- output stage: sum = p ^ carry-in (G shifted up), per share ----
  logic [WIDTH-1:0] s0_p, s1_p;
  logic             c0_p, c1_p, ov_p;
  wire  [WIDTH-1:0] cin0 = {g_s0[LEVELS][WIDTH-2:0], 1'b0};
  wire  [WIDTH-1:0] cin1 = {g_s1[LEVELS][WIDTH-2:0], 1'b0};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ov_p <= 1'b0;
      s0_p <= '0;
      s1_p <= '0;
      c0_p <= 1'b0;
      c1_p <= 1'b0;
    end else begin
      ov_p <= vld_p[LEVELS];
      if (vld_p[LEVELS]) begin
        s0_p <= pd0_p[LEVELS] ^ cin0;
        s1_p <= pd1_p[LEVELS] ^ cin1;
        c0_p <= g_s0[LEVELS][WIDTH-1];
        c1_p <= g_s1[LEVELS][WIDTH-1];
      end
    end
  end

  assign o_valid = ov_p;
  assign o_s0    = s0_p;
  assign o_s1    = s1_p;
  assign o_cout0 = c0_p;
  assign o_cout1 = c1_p;

endmodule

// File: tb/tb_masked_ks_adder.sv
// Randomised bench for masked_ks_adder (WIDTH=8) against a plain-arithmetic
// reference of the unmasked sum and carry-out.
module tb_masked_ks_adder;

  localparam int W   = 8;
  localparam int RW  = 42;
  localparam int LAT = 5;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         valid = 1'b0;
  logic [W-1:0] a0 = '0, a1 = '0, b0 = '0, b1 = '0;
  logic [RW-1:0] rnd = '0;
  wire          ov;
  wire  [W-1:0] s0, s1;
  wire          c0, c1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  masked_ks_adder #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_valid (valid),
    .i_a0    (a0),
    .i_a1    (a1),
    .i_b0    (b0),
    .i_b1    (b1),
    .i_rnd   (rnd),
    .o_valid (ov),
    .o_s0    (s0),
    .o_s1    (s1),
    .o_cout0 (c0),
    .o_cout1 (c1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RW-1:0] rand_rnd();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[RW-1:0];
  endfunction

  function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  task automatic drive_token(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] ma, mb;
    ma = W'($urandom());
    mb = W'($urandom());
    valid = 1'b1;
    a1 = ma;
    a0 = a ^ ma;
    b1 = mb;
    b0 = b ^ mb;
    rnd = rand_rnd();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid = 1'b0;
    rnd = rand_rnd();
    step();
    step();
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", ov); end
    total++; if (s0 !== '0) begin bad++; $display("FAIL reset_s0 got=%h exp=00", s0); end
    total++; if (s1 !== '0) begin bad++; $display("FAIL reset_s1 got=%h exp=00", s1); end
    total++; if (c0 !== 1'b0) begin bad++; $display("FAIL reset_c0 got=%b exp=0", c0); end
    total++; if (c1 !== 1'b0) begin bad++; $display("FAIL reset_c1 got=%b exp=0", c1); end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    a0 = 8'h5A; a1 = 8'h00; b0 = 8'h3C; b1 = 8'h00;
    rnd = '0;
    valid = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      step();
      valid = 1'b0;
      total++;
      if (ov !== (k == LAT)) begin
        bad++; $display("FAIL directed_valid cycle=%0d got=%b exp=%b", k, ov, (k == LAT));
      end
      if (k == LAT) begin
        total++; if ((s0 ^ s1) !== 8'h96) begin bad++; $display("FAIL directed_sum got=%h exp=96", s0 ^ s1); end
        total++; if ((c0 ^ c1) !== 1'b0) begin bad++; $display("FAIL directed_cout got=%b exp=0", c0 ^ c1); end
      end
    end
  endtask

  task automatic test_carry();
    a0 = 8'hA5; a1 = 8'h5A; b0 = 8'h33; b1 = 8'h32;
    rnd = rand_rnd();
    valid = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      step();
      valid = 1'b0;
      rnd = rand_rnd();
      total++;
      if (ov !== (k == LAT)) begin
        bad++; $display("FAIL carry_valid cycle=%0d got=%b exp=%b", k, ov, (k == LAT));
      end
      if (k == LAT) begin
        total++; if ((s0 ^ s1) !== 8'h00) begin bad++; $display("FAIL carry_sum got=%h exp=00", s0 ^ s1); end
        total++; if ((c0 ^ c1) !== 1'b1) begin bad++; $display("FAIL carry_cout got=%b exp=1", c0 ^ c1); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0]   exp_q[$];
    int           cyc_q[$];
    logic [W-1:0] a, b;
    logic [W:0]   e;
    int           n_in;
    int           got = 0;
    for (int n = 0; n < 100 + LAT; n++) begin
      if (n < 100) begin
        a = W'($urandom());
        b = W'($urandom());
        drive_token(a, b);
        exp_q.push_back(ref_add(a, b));
        cyc_q.push_back(n);
      end else begin
        valid = 1'b0;
        rnd = rand_rnd();
      end
      step();
      if (ov === 1'b1) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL b2b_extra cycle=%0d got=valid exp=idle", n);
        end else begin
          e = exp_q.pop_front();
          n_in = cyc_q.pop_front();
          got++;
          if ((s0 ^ s1) !== e[W-1:0]) begin bad++; $display("FAIL b2b_sum cycle=%0d got=%h exp=%h", n, s0 ^ s1, e[W-1:0]); end
          total++; if ((c0 ^ c1) !== e[W]) begin bad++; $display("FAIL b2b_cout cycle=%0d got=%b exp=%b", n, c0 ^ c1, e[W]); end
          total++; if (n !== n_in + LAT - 1) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", n - n_in + 1, LAT); end
        end
      end
    end
    valid = 1'b0;
    total++; if (got !== 100) begin bad++; $display("FAIL b2b_count got=%0d exp=100", got); end
  endtask

  task automatic test_bubbles();
    logic         pat [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [W:0]   exp_q[$];
    logic [W:0]   last = '0;
    bit           have_last = 1'b0;
    logic         exp_ov;
    logic [W-1:0] a, b;
    for (int n = 0; n < 11; n++) begin
      if (n < 5 && pat[n]) begin
        a = W'($urandom());
        b = W'($urandom());
        drive_token(a, b);
        exp_q.push_back(ref_add(a, b));
      end else begin
        valid = 1'b0;
        rnd = rand_rnd();
      end
      step();
      exp_ov = (n >= LAT - 1 && n < LAT + 4) ? pat[n-LAT+1] : 1'b0;
      total++; if (ov !== exp_ov) begin bad++; $display("FAIL bubble_valid cycle=%0d got=%b exp=%b", n, ov, exp_ov); end
      if (exp_ov && exp_q.size() > 0) begin
        last = exp_q.pop_front();
        have_last = 1'b1;
      end
      if (have_last) begin
        total++; if ((s0 ^ s1) !== last[W-1:0]) begin bad++; $display("FAIL bubble_sum cycle=%0d got=%h exp=%h", n, s0 ^ s1, last[W-1:0]); end
        total++; if ((c0 ^ c1) !== last[W]) begin bad++; $display("FAIL bubble_cout cycle=%0d got=%b exp=%b", n, c0 ^ c1, last[W]); end
      end
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] a, b;
    logic [W:0]   e;
    for (int n = 0; n < 3; n++) begin
      drive_token(W'($urandom()), W'($urandom()));
      step();
    end
    valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    total++; if (ov !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", ov); end
    total++; if (s0 !== '0) begin bad++; $display("FAIL arst_s0 got=%h exp=00", s0); end
    total++; if (s1 !== '0) begin bad++; $display("FAIL arst_s1 got=%h exp=00", s1); end
    total++; if ({c0, c1} !== 2'b00) begin bad++; $display("FAIL arst_cout got=%b%b exp=00", c0, c1); end
    step();
    step();
    rst = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      total++; if (ov !== 1'b0) begin bad++; $display("FAIL arst_flushed cycle=%0d got=%b exp=0", n, ov); end
    end
    a = W'($urandom());
    b = W'($urandom());
    e = ref_add(a, b);
    drive_token(a, b);
    for (int k = 1; k <= LAT + 1; k++) begin
      step();
      valid = 1'b0;
      rnd = rand_rnd();
      total++;
      if (ov !== (k == LAT)) begin
        bad++; $display("FAIL arst_new_valid cycle=%0d got=%b exp=%b", k, ov, (k == LAT));
      end
      if (k == LAT) begin
        total++; if ((s0 ^ s1) !== e[W-1:0]) begin bad++; $display("FAIL arst_new_sum got=%h exp=%h", s0 ^ s1, e[W-1:0]); end
        total++; if ((c0 ^ c1) !== e[W]) begin bad++; $display("FAIL arst_new_cout got=%b exp=%b", c0 ^ c1, e[W]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_carry();
    test_back_to_back();
    test_bubbles();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/masked_ks_adder.md
# masked_ks_adder

Pipelined, two-share, domain-oriented-masked (DOM) Kogge-Stone adder of parametrised width. It generalises the combinational masked black cell into a full masked adder. Every non-linear stage is registered and consumes fresh randomness every cycle, and a valid bit travels with each operand pair. It sits in the masked datapath wherever shared operands need an arithmetic add without unmasking.

## Interface
Parameters:
- WIDTH, 8: operand width; must be a power of two and at least 2, otherwise elaboration fails.
- LEVELS, clog2(WIDTH): prefix levels; derived, not overridable.
- RND_W, WIDTH + sum over l<LEVELS of 2*(WIDTH-2^l): fresh random bits per cycle; 42 for WIDTH=8.

Ports:
- i_clk  in  1  single clock, rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  operand shares valid this cycle
- i_a0, i_a1  in  WIDTH  shares of A; A = i_a0 ^ i_a1
- i_b0, i_b1  in  WIDTH  shares of B
- i_rnd  in  RND_W  fresh uniform randomness, required every cycle
- o_valid  out  1  result shares valid
- o_s0, o_s1  out  WIDTH  shares of (A+B) mod 2^WIDTH
- o_cout0, o_cout1  out  1  shares of carry-out

## Operation
- No backpressure. Every stage advances every cycle, and a token is accepted on any cycle with i_valid=1.
- Stage 0:
  - p = a ^ b is computed per share, which is linear.
  - g = a & b uses a DOM AND per bit, with randomness i_rnd[WIDTH-1:0].
- Prefix level l (l=0..LEVELS-1), distance d=2^l, for bits i>=d:
  - G_i' = G_i ^ (P_i & G_{i-d})
  - P_i' = P_i & P_{i-d}
  - Each of the two ANDs is a DOM AND with its own fresh bit.
  - Bits i<d pass through registered.
- DOM AND, shares (x0,x1),(y0,y1), fresh z:
  - Register x0&y0, (x0&y1)^z, (x1&y0)^z and x1&y1.
  - Out0 is the XOR of the first two registered terms; out1 is the XOR of the last two.
  - Compression XOR is after the register.
- Randomness slicing:
  - Stage 0 uses the lowest WIDTH bits.
  - Level l then uses the next 2*(WIDTH-d) bits: G products first, then P products, ascending bit index.
  - Each slice is consumed by whichever token occupies that stage in the current cycle.
- Original p shares are carried through the pipeline alongside G/P, domain-separated, never XORed across shares.
- Output stage:
  - s_i = p_i ^ G_{i-1}, with carry-in 0, so s_0 = p_0.
  - cout = G_{WIDTH-1}.
  - Computed per share and registered.
- Share 0 and share 1 logic never mix except through the randomised cross terms.

## Timing
- Latency L = LEVELS + 2 cycles from i_valid to o_valid; L=5 for WIDTH=8.
- Throughput is one result per cycle; back-to-back tokens are independent.
- Bubbles:
  - On a cycle with i_valid=0, the valid pipeline carries 0.
  - Data registers of invalid stages hold their value (enable = stage valid), so no cross-domain toggling occurs on garbage.
  - o_s*/o_cout* hold the last valid result while o_valid=0.
- Reset:
  - Asynchronous assertion clears all valid bits and all data/share registers to 0.
  - During reset, o_valid=0, o_s0=o_s1=0 and o_cout0=o_cout1=0.
  - Tokens in flight at reset are lost and produce no o_valid.
  - The first token is accepted on the first rising edge after deassertion.
- Unmasked results are independent of i_rnd values; only shares differ.

## Structure
- Package masked_pkg holds:
  - functions ks_levels(width) and ks_rnd_w(width);
  - function ks_rnd_off(width, level) for slice offsets;
  - a share-pair typedef for WIDTH-bit vectors.
- Sub-module dom_and_reg: one-bit registered DOM AND with inputs x0, x1, y0, y1, z and enable, and outputs q0, q1. It is instantiated WIDTH + RND_W-WIDTH times.
- Top level contains the generate loops for the levels, the p-share delay line, the valid shift register and the output stage.

## Test plan
- WIDTH=8, i_a0=0x5A, i_a1=0x00, i_b0=0x3C, i_b1=0x00, i_rnd=0 -> after 5 cycles o_valid=1, o_s0^o_s1=0x96, cout shares XOR 0.
- 0xFF+0x01 given with random shares (i_a0=0xA5, i_a1=0x5A, i_b0=0x33, i_b1=0x32) and random i_rnd -> sum XOR 0x00, cout XOR 1.
- 100 back-to-back random tokens, random shares and i_rnd each cycle -> every o_valid cycle matches the reference sum and cout, in order, 5 cycles later.
- Valid pattern 1,0,0,1,1 -> o_valid is the same pattern delayed 5; outputs hold during gaps.
- i_rst asserted asynchronously while 3 tokens are in flight -> outputs immediately 0, no o_valid for those tokens; a new token after release returns correctly at latency 5.
- WIDTH=16 and WIDTH=2 regressions: RND_W = 114 and 4 respectively; exhaustive (WIDTH=2) or random (WIDTH=16) checks pass; WIDTH=12 fails elaboration.
